// File: rtl/z80_int_ctrl.sv
// Interrupt controller for vz80core: I register, IFF1/IFF2, interrupt mode and NMI/INT service sequencing.
// Optional IM0 opcode-fetch service is enabled by defining Z80_INTCTRL_IM0_EN; otherwise IM0 is serviced as IM1.
module z80_int_ctrl #(
    parameter logic [15:0] NMI_VEC = 16'h0066,
    parameter logic [15:0] IM1_VEC = 16'h0038
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        nmi_n,
    input  logic        int_n,
    input  logic        insn_done,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [7:0]  op_data,
    output logic        irq_req,
    output logic [1:0]  irq_kind,
    input  logic        irq_ack,
    input  logic        vec_valid,
    input  logic [7:0]  vec_data,
    output logic        target_valid,
    output logic [15:0] target_pc,
    output logic [7:0]  target_op,
    output logic        target_is_op,
    output logic [7:0]  i_q,
    output logic        iff1,
    output logic        iff2,
    output logic [1:0]  im
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_VEC,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        K_NMI = 2'd0,
        K_IM0 = 2'd1,
        K_IM1 = 2'd2,
        K_IM2 = 2'd3
    } kind_t;

    typedef enum logic [2:0] {
        OP_DI     = 3'd0,
        OP_EI     = 3'd1,
        OP_IM0    = 3'd2,
        OP_IM1    = 3'd3,
        OP_IM2    = 3'd4,
        OP_LD_I_A = 3'd5,
        OP_RETN   = 3'd6,
        OP_NOP    = 3'd7
    } op_t;

    state_t      state, state_n;
    kind_t       kind, kind_n;

    logic        nmi_s1, nmi_s2, nmi_prev;
    logic        int_s1, int_s2;
    logic        nmi_edge;
    logic        nmi_pend, nmi_pend_n;
    logic        ei_block, ei_block_n, ei_eff;

    logic        iff1_n, iff2_n;
    logic [1:0]  im_n;
    logic [7:0]  i_n;
    logic [15:0] target_pc_n;
    logic [7:0]  target_op_n;
    logic        target_is_op_n;

    function automatic kind_t kind_for_im(input logic [1:0] m);
        case (m)
`ifdef Z80_INTCTRL_IM0_EN
            2'd0:    kind_for_im = K_IM0;
`else
            2'd0:    kind_for_im = K_IM1;
`endif
            2'd2:    kind_for_im = K_IM2;
            default: kind_for_im = K_IM1;
        endcase
    endfunction

    assign nmi_edge     = nmi_prev & ~nmi_s2;
    assign irq_req      = (state == S_PEND);
    assign target_valid = (state == S_DONE);
    assign irq_kind     = kind;

    always_comb begin
        state_n        = state;
        kind_n         = kind;
        iff1_n         = iff1;
        iff2_n         = iff2;
        im_n           = im;
        i_n            = i_q;
        target_pc_n    = target_pc;
        target_op_n    = target_op;
        target_is_op_n = target_is_op;
        nmi_pend_n     = nmi_pend | nmi_edge;
        ei_eff         = ei_block;

        // Same-cycle ops land before the boundary decision, so the decision uses the *_n values.
        if (state == S_IDLE && op_valid) begin
            case (op)
                OP_DI:     begin iff1_n = 1'b0; iff2_n = 1'b0; end
                OP_EI:     begin iff1_n = 1'b1; iff2_n = 1'b1; ei_eff = 1'b1; end
                OP_IM0:    im_n = 2'd0;
                OP_IM1:    im_n = 2'd1;
                OP_IM2:    im_n = 2'd2;
                OP_LD_I_A: i_n = op_data;
                OP_RETN:   iff1_n = iff2;
                default:   ;
            endcase
        end
        ei_block_n = insn_done ? 1'b0 : ei_eff;

        case (state)
            S_IDLE: begin
                if (insn_done) begin
                    if (nmi_pend) begin
                        state_n = S_PEND;
                        kind_n  = K_NMI;
                    end else if (!int_s2 && iff1_n && !ei_eff) begin
                        state_n = S_PEND;
                        kind_n  = kind_for_im(im_n);
                    end
                end
            end
            S_PEND: begin
                if (irq_ack) begin
                    if (kind == K_NMI) begin
                        iff2_n         = iff1;
                        iff1_n         = 1'b0;
                        nmi_pend_n     = nmi_edge;
                        target_pc_n    = NMI_VEC;
                        target_op_n    = '0;
                        target_is_op_n = 1'b0;
                        state_n        = S_DONE;
                    end else begin
                        iff1_n = 1'b0;
                        iff2_n = 1'b0;
                        if (kind == K_IM1) begin
                            target_pc_n    = IM1_VEC;
                            target_op_n    = '0;
                            target_is_op_n = 1'b0;
                            state_n        = S_DONE;
                        end else begin
                            state_n = S_VEC;
                        end
                    end
                end
            end
            S_VEC: begin
                if (vec_valid) begin
                    state_n = S_DONE;
                    if (kind == K_IM0) begin
                        target_pc_n    = '0;
                        target_op_n    = vec_data;
                        target_is_op_n = 1'b1;
                    end else begin
                        target_pc_n    = {i_q, vec_data};
                        target_op_n    = '0;
                        target_is_op_n = 1'b0;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            kind         <= K_NMI;
            nmi_s1       <= 1'b1;
            nmi_s2       <= 1'b1;
            nmi_prev     <= 1'b1;
            int_s1       <= 1'b1;
            int_s2       <= 1'b1;
            nmi_pend     <= 1'b0;
            ei_block     <= 1'b0;
            iff1         <= 1'b0;
            iff2         <= 1'b0;
            im           <= 2'd0;
            i_q          <= '0;
            target_pc    <= '0;
            target_op    <= '0;
            target_is_op <= 1'b0;
        end else begin
            state        <= state_n;
            kind         <= kind_n;
            nmi_s1       <= nmi_n;
            nmi_s2       <= nmi_s1;
            nmi_prev     <= nmi_s2;
            int_s1       <= int_n;
            int_s2       <= int_s1;
            nmi_pend     <= nmi_pend_n;
            ei_block     <= ei_block_n;
            iff1         <= iff1_n;
            iff2         <= iff2_n;
            im           <= im_n;
            i_q          <= i_n;
            target_pc    <= target_pc_n;
            target_op    <= target_op_n;
            target_is_op <= target_is_op_n;
        end
    end

endmodule

// File: doc/z80_int_ctrl.md
# z80_int_ctrl

Interrupt controller for the vz80core CPU, owning the I register, IFF1/IFF2 and the interrupt mode. It samples /NMI and /INT at instruction boundaries and requests interrupt service from the core sequencer. On acknowledge it produces the service target: a fixed vector for NMI and IM1, the I-based table address for IM2, or an opcode byte for IM0. Sits beside the core's instruction sequencer. The sequencer reports decoded DI/EI/IM/LD I,A/RETN effects here, and reads I and IFF2 back for LD A,I.

## Interface
Parameters:
- NMI_VEC, 16'h0066, NMI service address
- IM1_VEC, 16'h0038, IM1 service address

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- nmi_n  in  1  external /NMI, asynchronous
- int_n  in  1  external /INT, asynchronous, level
- insn_done  in  1  core pulse: instruction boundary this cycle
- op_valid  in  1  op strobe
- op  in  3  0 DI, 1 EI, 2 IM0, 3 IM1, 4 IM2, 5 LD_I_A, 6 RETN (RETI also uses 6), 7 reserved (no-op)
- op_data  in  8  A value for LD_I_A
- irq_req  out  1  service requested, held until irq_ack
- irq_kind  out  2  0 NMI, 1 IM0, 2 IM1, 3 IM2
- irq_ack  in  1  core accepts request
- vec_valid  in  1  acknowledge-cycle data bus byte valid
- vec_data  in  8  acknowledge-cycle data bus byte
- target_valid  out  1  one-cycle pulse: target outputs valid
- target_pc  out  16  service address (NMI/IM1/IM2)
- target_op  out  8  IM0 opcode byte
- target_is_op  out  1  1 = execute target_op instead of jumping
- i_q  out  8  I register
- iff1, iff2  out  1  interrupt flip-flops
- im  out  2  current mode 0/1/2

## Operation
- Sync: nmi_n and int_n each pass through a 2-flop synchronizer.
- NMI: a falling edge of the synced nmi_n sets nmi_pend. nmi_pend clears on irq_ack while irq_kind=NMI. An edge arriving in that same cycle re-sets it.
- INT: the synced int_n is sampled as a level; no latching.
- Ops are applied only in IDLE; they are ignored in other states.
  - DI: iff1=iff2=0.
  - EI: iff1=iff2=1, ei_block=1.
  - IMn: im=n.
  - LD_I_A: i_q=op_data.
  - RETN: iff1=iff2.
- ei_block: cleared at every insn_done. While set, INT is not accepted, so the boundary of EI itself is never interruptible. If op EI and insn_done coincide, ei_block stays set for that cycle's decision and clears afterwards.
- Boundary decision, IDLE with insn_done:
  - If nmi_pend, go to PEND with kind NMI.
  - Otherwise, if the synced int_n=0 and iff1=1 and the effective ei_block=0, go to PEND with kind from im.
  - Ops in the same cycle take effect before the decision. Example: DI with insn_done blocks INT.
- FSM states: IDLE, PEND, VEC, DONE.
  - PEND: irq_req=1. On irq_ack:
    - NMI: iff2=iff1, iff1=0, go to DONE.
    - INT: iff1=iff2=0. IM1 goes to DONE; IM0 and IM2 go to VEC.
  - VEC: wait for vec_valid. Capture vec_data, then go to DONE.
  - DONE: target_valid=1 for one cycle, then go to IDLE.
- Targets:
  - NMI: NMI_VEC.
  - IM1: IM1_VEC.
  - IM2: {i_q, vec_data}, full byte, LSB not forced.
  - IM0: target_is_op=1, target_op=vec_data, target_pc=0.
- Reset mid-operation: everything returns to reset values immediately, and a pending request is dropped.

## Timing
- Reset values: i_q=0, iff1=iff2=0, im=0, irq_req=0, irq_kind=0, target_valid=0, target_pc=0, target_op=0, target_is_op=0. nmi_pend=0, ei_block=0, synchronizers=1.
- Pin-to-sample latency: 2 cycles.
- irq_req rises the cycle after the deciding insn_done.
- irq_ack takes effect in the cycle it is sampled high with irq_req=1.
- NMI/IM1: target_valid is high the cycle after the ack.
- IM0/IM2: target_valid is high the cycle after vec_valid is sampled in VEC. vec_valid is ignored outside VEC.
- Target outputs hold their value until the next DONE.

## Configuration
- Z80_INTCTRL_IM0_EN defined: IM0 behaves as above.
- Undefined: IM0 is serviced exactly as IM1. irq_kind reports 2, there is no VEC state, target_pc=IM1_VEC, and target_is_op stays 0.

## Test plan
- Reset: reset_n low mid-PEND gives irq_req=0, iff1=0, i_q=0. Release gives IDLE.
- IM2 with I=8'h3A (LD_I_A op_data=3A), EI, int_n low, insn_done at the EI boundary, then the next boundary:
  - No request at the EI boundary; irq_kind=3 after the next boundary.
  - Ack, then vec_valid with 8'hF1, gives target_pc=16'h3AF1 and iff1=iff2=0.
- NMI over INT: iff1=1, IM1, NMI edge and int_n low both pending at insn_done give kind=0. After ack, target_pc=16'h0066, iff1=0, iff2=1. RETN restores iff1=1.
- EI chain: EI at three consecutive boundaries with int_n low gives no request. A following non-EI boundary gives a request.
- DI coincident with insn_done, int_n low, iff1=1: no request; iff1=iff2=0.
- IM0 with macro: vec_data=8'hFF gives target_is_op=1, target_op=8'hFF. Without macro: irq_kind=2, target_pc=16'h0038.
